// File: rtl/miriscv_pkg.sv
// miriscv_pkg: shared RV32 core constants.
package miriscv_pkg;
   localparam int XLEN = 32;
endpackage

// File: rtl/miriscv_mul_ctrl.sv
// miriscv_mul_ctrl: RV32M multiply sequencer around an external multi-cycle multiplier.
// Define MIRISCV_MUL_CACHE_EN to add a last-product cache that bypasses the multiplier on a hit.
module miriscv_mul_ctrl
   import miriscv_pkg::*;
(
   input  logic                clk_i,
   input  logic                arstn_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [1:0]          mdu_op_i,
   input  logic [XLEN-1:0]     operand_a_i,
   input  logic [XLEN-1:0]     operand_b_i,
   input  logic                kill_i,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [XLEN-1:0]     res_o,
   output logic                mul_start_o,
   output logic [XLEN:0]       mul_operand_a_o,
   output logic [XLEN:0]       mul_operand_b_o,
   input  logic [2*XLEN+1:0]   mul_result_i,
   input  logic                mul_stall_req_i
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_e;
   state_e              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [XLEN:0]       a_q, a_d, b_q, b_d;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic [2*XLEN-1:0]   hit_prod;
   logic                accept, hit, a_sgn, b_sgn;
   logic                unused_res_hi;
   assign unused_res_hi = ^mul_result_i[2*XLEN+1:2*XLEN];
   assign accept = state_q == IDLE && req_valid_i && !kill_i;
   assign a_sgn  = mdu_op_i != 2'b11;
   assign b_sgn  = !mdu_op_i[1];
   assign req_ready_o     = state_q == IDLE;
   assign mul_start_o     = state_q == BUSY;
   assign res_valid_o     = state_q == DONE;
   assign mul_operand_a_o = a_q;
   assign mul_operand_b_o = b_q;
   assign res_o           = op_q == 2'b00 ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
`ifdef MIRISCV_MUL_CACHE_EN
   logic                cache_vld_q, cache_vld_d, hit_q, hit_d;
   logic [XLEN-1:0]     cache_a_q, cache_a_d, cache_b_q, cache_b_d;
   logic [1:0]          cache_op_q, cache_op_d;
   logic [2*XLEN-1:0]   cache_prod_q, cache_prod_d;
   // MUL only needs the low word, which is identical for every signedness
   assign hit = cache_vld_q && operand_a_i == cache_a_q && operand_b_i == cache_b_q &&
                (mdu_op_i == 2'b00 || mdu_op_i == cache_op_q);
   assign hit_prod = cache_prod_q;
   always_comb begin
      hit_d        = accept ? hit : hit_q;
      cache_vld_d  = cache_vld_q;
      cache_a_d    = cache_a_q;
      cache_b_d    = cache_b_q;
      cache_op_d   = cache_op_q;
      cache_prod_d = cache_prod_q;
      if (state_q == DONE && res_ready_i && !kill_i && !hit_q) begin
         cache_vld_d  = 1'b1;
         cache_a_d    = a_q[XLEN-1:0];
         cache_b_d    = b_q[XLEN-1:0];
         cache_op_d   = op_q;
         cache_prod_d = prod_q;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!arstn_i) begin
         hit_q        <= 1'b0;
         cache_vld_q  <= 1'b0;
         cache_a_q    <= '0;
         cache_b_q    <= '0;
         cache_op_q   <= '0;
         cache_prod_q <= '0;
      end else begin
         hit_q        <= hit_d;
         cache_vld_q  <= cache_vld_d;
         cache_a_q    <= cache_a_d;
         cache_b_q    <= cache_b_d;
         cache_op_q   <= cache_op_d;
         cache_prod_q <= cache_prod_d;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_prod = '0;
`endif
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      unique case (state_q)
         IDLE: if (accept) begin
            op_d    = mdu_op_i;
            a_d     = {a_sgn & operand_a_i[XLEN-1], operand_a_i};
            b_d     = {b_sgn & operand_b_i[XLEN-1], operand_b_i};
            prod_d  = hit ? hit_prod : prod_q;
            state_d = hit ? DONE : BUSY;
         end
         BUSY: if (kill_i) state_d = DRAIN;
            else if (!mul_stall_req_i) begin
               prod_d  = mul_result_i[2*XLEN-1:0];
               state_d = DONE;
            end
         DONE: state_d = kill_i || res_ready_i ? IDLE : DONE;
         // the multiplier still spends one FINISH cycle after start drops
         DRAIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!arstn_i) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
      end
   end
endmodule

// File: tb/tb_miriscv_mul_ctrl.sv
// tb_miriscv_mul_ctrl: scoreboard bench with a two-cycle behavioural multiplier.
module tb_miriscv_mul_ctrl;
   logic        clk = 1'b0, arstn_i = 1'b0;
   logic        req_valid_i = 1'b0, kill_i = 1'b0, res_ready_i = 1'b1;
   logic [1:0]  mdu_op_i = '0;
   logic [31:0] operand_a_i = '0, operand_b_i = '0;
   logic        req_ready_o, res_valid_o, mul_start_o, mul_stall_req_i;
   logic [31:0] res_o;
   logic [32:0] mul_operand_a_o, mul_operand_b_o;
   logic [65:0] mul_result_i;
   logic signed [65:0] pa, pb;
   logic        seen = 1'b0;
   logic [31:0] exp_q[$];
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   miriscv_mul_ctrl dut (
      .clk_i(clk), .arstn_i(arstn_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .mdu_op_i(mdu_op_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
      .kill_i(kill_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o),
      .mul_start_o(mul_start_o), .mul_operand_a_o(mul_operand_a_o),
      .mul_operand_b_o(mul_operand_b_o), .mul_result_i(mul_result_i),
      .mul_stall_req_i(mul_stall_req_i)
   );

   // stall on the first start cycle, product ready on the second
   assign pa = {{33{mul_operand_a_o[32]}}, mul_operand_a_o};
   assign pb = {{33{mul_operand_b_o[32]}}, mul_operand_b_o};
   assign mul_result_i = pa * pb;
   assign mul_stall_req_i = mul_start_o && !seen;
   always @(posedge clk) seen <= mul_start_o;

   always @(negedge clk) begin
      if (arstn_i && res_valid_o && res_ready_i && !kill_i) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result got=%h", res_o);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (res_o !== e) begin
               fails++;
               $display("FAIL result got=%h exp=%h", res_o, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp);
      int n = 0;
      while (!req_ready_o && n < 50) begin step(); n++; end
      check("ready_wait", {31'b0, req_ready_o}, 32'd1);
      req_valid_i = 1'b1; mdu_op_i = op; operand_a_i = a; operand_b_i = b;
      if (push) exp_q.push_back(exp);
      step();
      req_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || !req_ready_o) && n < 50) begin step(); n++; end
      check("drain_timeout", {31'b0, exp_q.size() == 0 && req_ready_o}, 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 arstn_i = 1'b1;
      check("rst_ready", {31'b0, req_ready_o}, 32'd1);
      check("rst_valid", {31'b0, res_valid_o}, 32'd0);
      check("rst_start", {31'b0, mul_start_o}, 32'd0);
      check("rst_res", res_o, 32'd0);

      send(2'b01, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000);
      check("lat_e0_start", {31'b0, mul_start_o}, 32'd1);
      check("lat_e0_valid", {31'b0, res_valid_o}, 32'd0);
      step();
      check("lat_e1_valid", {31'b0, res_valid_o}, 32'd0);
      step();
      check("lat_e2_valid", {31'b0, res_valid_o}, 32'd1);
      check("lat_e2_start", {31'b0, mul_start_o}, 32'd0);
      wait_idle();

      send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE);
      send(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0001);
      send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
      wait_idle();

      res_ready_i = 1'b0;
      send(2'b00, 32'd7, 32'd9, 1, 32'h0000_003F);
      for (int i = 0; i < 3 && !res_valid_o; i++) step();
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {31'b0, res_valid_o}, 32'd1);
         check("hold_res", res_o, 32'h0000_003F);
         check("hold_ready", {31'b0, req_ready_o}, 32'd0);
         step();
      end
      res_ready_i = 1'b1;
      wait_idle();

      send(2'b00, 32'd2, 32'd3, 0, 32'd0);
      check("kill_busy_start", {31'b0, mul_start_o}, 32'd1);
      kill_i = 1'b1;
      step();
      kill_i = 1'b0;
      check("drain_start", {31'b0, mul_start_o}, 32'd0);
      check("drain_ready", {31'b0, req_ready_o}, 32'd0);
      check("drain_valid", {31'b0, res_valid_o}, 32'd0);
      step();
      check("post_drain_ready", {31'b0, req_ready_o}, 32'd1);
      send(2'b00, 32'd3, 32'd5, 1, 32'h0000_000F);
      wait_idle();

      send(2'b01, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFF);
      wait_idle();
      send(2'b00, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFE);
`ifdef MIRISCV_MUL_CACHE_EN
      check("hit_valid", {31'b0, res_valid_o}, 32'd1);
      check("hit_start", {31'b0, mul_start_o}, 32'd0);
`else
      check("miss_valid", {31'b0, res_valid_o}, 32'd0);
      check("miss_start", {31'b0, mul_start_o}, 32'd1);
`endif
      wait_idle();

      send(2'b00, 32'd5, 32'd6, 0, 32'd0);
      arstn_i = 1'b0;
      step();
      arstn_i = 1'b1;
      check("mid_rst_ready", {31'b0, req_ready_o}, 32'd1);
      check("mid_rst_valid", {31'b0, res_valid_o}, 32'd0);
      check("mid_rst_start", {31'b0, mul_start_o}, 32'd0);
      check("mid_rst_res", res_o, 32'd0);
      send(2'b11, 32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0001);
      wait_idle();
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
